// File: rtl/block_lock_extractor.sv
// Confirms the aligner's candidate 64b/66b offset with consecutive good sync headers, then holds it,
// extracts aligned 66-bit blocks and drops lock when too many bad headers land in one window.
module block_lock_extractor #(
    parameter int LOCK_CNT = 64,
    parameter int WIN_LEN  = 1024,
    parameter int BAD_MAX  = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [193:0] gbox_buffer,
    input  logic         buffer_dv,
    input  logic         is_synced,
    input  logic [6:0]   offset_pos,
    output logic [1:0]   blk_hdr,
    output logic [63:0]  blk_data,
    output logic         blk_dv,
    output logic         locked,
    output logic [6:0]   lock_offset,
    output logic [7:0]   unlock_cnt
);

    localparam int GW = $clog2(LOCK_CNT) + 1;
    localparam int WW = $clog2(WIN_LEN) + 1;
    localparam int BW = $clog2(BAD_MAX) + 1;
    localparam logic [7:0] MAX_OFFSET = 8'd128;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_CHECK,
        ST_LOCKED
    } state_e;

    state_e          state_q, state_d;
    logic [6:0]      lock_offset_q, lock_offset_d;
    logic [GW-1:0]   good_cnt_q, good_cnt_d;
    logic [WW-1:0]   win_cnt_q, win_cnt_d;
    logic [BW-1:0]   bad_cnt_q, bad_cnt_d;
    logic [1:0]      blk_hdr_q, blk_hdr_d;
    logic [63:0]     blk_data_q, blk_data_d;
    logic            blk_dv_q, blk_dv_d;
    logic            locked_q, locked_d;
    logic [7:0]      unlock_cnt_q, unlock_cnt_d;

    logic [65:0]     win;
    logic            hdr_good;
    logic            cand_ok;
    logic [GW-1:0]   good_inc;
    logic [BW-1:0]   bad_sum;

    // The header is always taken at the held offset, never at the aligner's live candidate.
    assign win      = 66'(gbox_buffer >> lock_offset_q);
    assign hdr_good = (win[65:64] == 2'b01) || (win[65:64] == 2'b10);
    assign cand_ok  = is_synced && ({1'b0, offset_pos} <= MAX_OFFSET);
    assign good_inc = good_cnt_q + GW'(1);
    assign bad_sum  = bad_cnt_q + BW'(!hdr_good);

    always_comb begin
        // NOTE: every next-state value defaults to hold first, so no path can infer a latch.
        state_d       = state_q;
        lock_offset_d = lock_offset_q;
        good_cnt_d    = good_cnt_q;
        win_cnt_d     = win_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        blk_hdr_d     = blk_hdr_q;
        blk_data_d    = blk_data_q;
        blk_dv_d      = 1'b0;
        unlock_cnt_d  = unlock_cnt_q;

        if (buffer_dv) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (cand_ok) begin
                        lock_offset_d = offset_pos;
                        good_cnt_d    = '0;
                        state_d       = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!cand_ok || (offset_pos != lock_offset_q)) begin
                        state_d = ST_HUNT;
                    end else if (!hdr_good) begin
                        state_d = ST_HUNT;
                    end else if (good_inc == GW'(LOCK_CNT)) begin
                        state_d   = ST_LOCKED;
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end
                ST_LOCKED: begin
                    // The block that trips unlock is still emitted so the decoder can flag it.
                    blk_dv_d   = 1'b1;
                    blk_hdr_d  = win[65:64];
                    blk_data_d = win[63:0];
                    if (bad_sum == BW'(BAD_MAX)) begin
                        state_d = ST_HUNT;
                        if (unlock_cnt_q != 8'hFF) begin
                            unlock_cnt_d = unlock_cnt_q + 8'd1;
                        end
                    end else if (win_cnt_q == WW'(WIN_LEN - 1)) begin
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WW'(1);
                        bad_cnt_d = bad_sum;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q       <= ST_HUNT;
            lock_offset_q <= '0;
            good_cnt_q    <= '0;
            win_cnt_q     <= '0;
            bad_cnt_q     <= '0;
            blk_hdr_q     <= '0;
            blk_data_q    <= '0;
            blk_dv_q      <= 1'b0;
            locked_q      <= 1'b0;
            unlock_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            lock_offset_q <= lock_offset_d;
            good_cnt_q    <= good_cnt_d;
            win_cnt_q     <= win_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            blk_hdr_q     <= blk_hdr_d;
            blk_data_q    <= blk_data_d;
            blk_dv_q      <= blk_dv_d;
            locked_q      <= locked_d;
            unlock_cnt_q  <= unlock_cnt_d;
        end
    end

    assign blk_hdr     = blk_hdr_q;
    assign blk_data    = blk_data_q;
    assign blk_dv      = blk_dv_q;
    assign locked      = locked_q;
    assign lock_offset = lock_offset_q;
    assign unlock_cnt  = unlock_cnt_q;

endmodule

// File: tb/tb_block_lock_extractor.sv
// Directed bench for block_lock_extractor: lock acquisition, offset change in CHECK, error-window
// hysteresis, dv gating, synchronous reset and extraction at the highest offset.
module tb_block_lock_extractor;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [193:0] gbox_buffer;
    logic         buffer_dv;
    logic         is_synced;
    logic [6:0]   offset_pos;
    logic [1:0]   blk_hdr;
    logic [63:0]  blk_data;
    logic         blk_dv;
    logic         locked;
    logic [6:0]   lock_offset;
    logic [7:0]   unlock_cnt;

    int checks = 0;
    int errors = 0;

    block_lock_extractor dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .gbox_buffer (gbox_buffer),
        .buffer_dv   (buffer_dv),
        .is_synced   (is_synced),
        .offset_pos  (offset_pos),
        .blk_hdr     (blk_hdr),
        .blk_data    (blk_data),
        .blk_dv      (blk_dv),
        .locked      (locked),
        .lock_offset (lock_offset),
        .unlock_cnt  (unlock_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Background of all-ones (bad header 2'b11 everywhere) with one 66-bit block placed at off.
    function automatic logic [193:0] mk(input int off, input logic [1:0] h, input logic [63:0] d);
        logic [193:0] b;
        logic [193:0] w;
        logic [193:0] m;
        b = '1;
        w = {128'b0, h, d};
        m = {128'b0, {66{1'b1}}};
        return (b & ~(m << off)) | (w << off);
    endfunction

    task automatic check_reset_values(input string pfx);
        check({pfx, "_locked"},      locked,      0);
        check({pfx, "_blk_dv"},      blk_dv,      0);
        check({pfx, "_lock_offset"}, lock_offset, 0);
        check({pfx, "_unlock_cnt"},  unlock_cnt,  0);
        check({pfx, "_blk_hdr"},     blk_hdr,     0);
        check({pfx, "_blk_data"},    blk_data,    0);
    endtask

    initial begin
        rst_i       = 1'b1;
        buffer_dv   = 1'b0;
        is_synced   = 1'b0;
        offset_pos  = '0;
        gbox_buffer = '0;
        step();
        step();
        check_reset_values("rst0");
        rst_i = 1'b0;

        // Acquire lock at offset 17: one HUNT cycle plus 64 good CHECK cycles.
        is_synced  = 1'b1;
        offset_pos = 7'd17;
        buffer_dv  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            gbox_buffer = mk(17, 2'b01, {32'hC0DE_0000, 32'(i)});
            step();
            check("acq_no_dv", blk_dv, 0);
        end
        check("acq_not_early", locked, 0);
        step();
        check("acq_locked", locked, 1);
        check("acq_offset", lock_offset, 17);
        check("acq_first_dv", blk_dv, 0);

        gbox_buffer = mk(17, 2'b10, 64'h0123_4567_89AB_CDEF);
        step();
        check("blk1_dv", blk_dv, 1);
        check("blk1_hdr", blk_hdr, 2'b10);
        check("blk1_data", blk_data, 64'h0123_4567_89AB_CDEF);

        // dv low while locked: no strobe, outputs hold, window does not advance.
        buffer_dv   = 1'b0;
        gbox_buffer = mk(17, 2'b00, 64'hFFFF_0000_FFFF_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("dvlow_dv", blk_dv, 0);
            check("dvlow_hold", blk_data, 64'h0123_4567_89AB_CDEF);
            check("dvlow_locked", locked, 1);
        end
        buffer_dv = 1'b1;

        // Window position is now 1. Fifteen bad headers stay below the threshold.
        for (int i = 0; i < 15; i++) begin
            gbox_buffer = mk(17, 2'b00, {32'hBAD0_0000, 32'(i)});
            step();
        end
        check("bad15_locked", locked, 1);
        check("bad15_dv", blk_dv, 1);
        check("bad15_hdr", blk_hdr, 2'b00);
        check("bad15_data", blk_data, {32'hBAD0_0000, 32'd14});

        // 1008 good blocks carry the window position from 16 through 1023 and clear it.
        for (int i = 0; i < 1008; i++) begin
            gbox_buffer = mk(17, 2'b01, {32'h600D_0000, 32'(i)});
            step();
        end
        check("wrap_locked", locked, 1);

        for (int i = 0; i < 15; i++) begin
            gbox_buffer = mk(17, 2'b00, {32'hBAD1_0000, 32'(i)});
            step();
        end
        check("bad15b_locked", locked, 1);
        check("bad15b_unlock_cnt", unlock_cnt, 0);

        // Bring the window to its last position, then the 16th bad header lands on the window end.
        for (int i = 0; i < 1008; i++) begin
            gbox_buffer = mk(17, 2'b01, {32'h600E_0000, 32'(i)});
            step();
        end
        check("pre_unlock_locked", locked, 1);
        gbox_buffer = mk(17, 2'b00, 64'h5555_AAAA_5555_AAAA);
        step();
        check("unlock_locked", locked, 0);
        check("unlock_cnt1", unlock_cnt, 1);
        check("unlock_blk_dv", blk_dv, 1);
        check("unlock_blk_hdr", blk_hdr, 2'b00);
        check("unlock_blk_data", blk_data, 64'h5555_AAAA_5555_AAAA);

        // Back in HUNT: re-enter CHECK at 17, then move the candidate to 18.
        gbox_buffer = mk(17, 2'b01, 64'h1111_2222_3333_4444);
        step();
        check("hunt_no_dv", blk_dv, 0);
        check("hunt_locked", locked, 0);
        check("hunt_offset", lock_offset, 17);
        for (int i = 0; i < 5; i++) step();
        offset_pos  = 7'd18;
        gbox_buffer = mk(18, 2'b01, 64'h1818_1818_1818_1818);
        step();
        check("move_to_hunt_offset", lock_offset, 17);
        check("move_to_hunt_locked", locked, 0);
        step();
        check("move_check_offset", lock_offset, 18);
        check("move_check_dv", blk_dv, 0);

        // 30 good headers in CHECK at 18, then ten dv-low cycles with hostile inputs.
        for (int i = 0; i < 30; i++) step();
        buffer_dv   = 1'b0;
        is_synced   = 1'b0;
        offset_pos  = 7'd5;
        gbox_buffer = mk(18, 2'b00, 64'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("freeze_locked", locked, 0);
            check("freeze_offset", lock_offset, 18);
            check("freeze_dv", blk_dv, 0);
        end
        buffer_dv   = 1'b1;
        is_synced   = 1'b1;
        offset_pos  = 7'd18;
        gbox_buffer = mk(18, 2'b01, 64'h1818_1818_1818_1818);
        for (int i = 0; i < 33; i++) step();
        check("freeze_resume_not_early", locked, 0);
        step();
        check("freeze_resume_locked", locked, 1);
        check("freeze_resume_offset", lock_offset, 18);

        gbox_buffer = mk(18, 2'b01, 64'hFEED_FACE_CAFE_BEEF);
        step();
        check("lock18_dv", blk_dv, 1);
        check("lock18_data", blk_data, 64'hFEED_FACE_CAFE_BEEF);

        // Synchronous reset while locked, with dv and a good block still presented.
        rst_i = 1'b1;
        step();
        check_reset_values("rst1");
        rst_i = 1'b0;

        // offset_pos is 7 bits wide, so an unusable candidate here means is_synced=0.
        is_synced   = 1'b0;
        offset_pos  = 7'd127;
        gbox_buffer = mk(127, 2'b01, 64'h7F7F_7F7F_7F7F_7F7F);
        for (int i = 0; i < 5; i++) begin
            step();
            check("unsynced_offset", lock_offset, 0);
        end
        is_synced = 1'b1;
        step();
        check("sync127_offset", lock_offset, 127);

        // A bad header in CHECK restarts acquisition: HUNT, then 64 fresh good headers.
        for (int i = 0; i < 3; i++) step();
        gbox_buffer = mk(127, 2'b11, 64'h0);
        step();
        gbox_buffer = mk(127, 2'b01, 64'h7F7F_7F7F_7F7F_7F7F);
        for (int i = 0; i < 64; i++) step();
        check("rechk_not_early", locked, 0);
        step();
        check("rechk_locked", locked, 1);
        gbox_buffer = mk(127, 2'b10, 64'hA1B2_C3D4_E5F6_0718);
        step();
        check("off127_dv", blk_dv, 1);
        check("off127_hdr", blk_hdr, 2'b10);
        check("off127_data", blk_data, 64'hA1B2_C3D4_E5F6_0718);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
